transaction_engine: RTL and testbench
=====================================

TRANSACTION_ENGINE -- requirements
Module: transaction_engine

Interface
REQ-001 Parameter ANIM_CYCLES, default 16, sets the number of cycles the ANIMATE state is held.
REQ-002 Parameter W, default 8, sets the balance, amount and key width.
REQ-003 clock  in  1  single clock; all logic is posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start_transaction  in  1  level from the main controller; high for the whole transaction request.
REQ-006 sender  in  1  0 = player 1 pays player 2; 1 = player 2 pays player 1.
REQ-007 amount  in  W  transfer amount, stable while start_transaction is high.
REQ-008 key  in  W  key entered by the user, stable while start_transaction is high.
REQ-009 mem_addr  out  2  memory address: 0 = P1 balance, 1 = P2 balance, 2 = P1 key, 3 = P2 key.
REQ-010 mem_rdata  in  W  synchronous-read data, valid one cycle after mem_addr is presented.
REQ-011 mem_wdata  out  W  write data.
REQ-012 mem_we  out  1  write strobe; high for exactly one cycle per write.
REQ-013 finished_transaction  out  1  done level to the main controller.
REQ-014 tx_ok  out  1  last transaction committed.
REQ-015 tx_reject  out  1  last transaction refused.
REQ-016 anim_active  out  1  high while the animation plays.

Function
REQ-017 The FSM SHALL have these states: IDLE, RD_KEY, RD_SRC, RD_DST, CHECK, WR_SRC, WR_DST, ANIMATE, DONE.
REQ-018 IDLE SHALL go to RD_KEY on start_transaction=1 and clear tx_ok and tx_reject on that transition.
REQ-019 RD_KEY SHALL drive mem_addr to the sender's key address (2+sender).
REQ-020 RD_SRC SHALL drive mem_addr=sender and capture mem_rdata as the stored key.
REQ-021 RD_DST SHALL drive mem_addr=~sender and capture mem_rdata as the source balance.
REQ-022 CHECK SHALL capture mem_rdata as the destination balance and evaluate the transfer in the same cycle.
REQ-023 CHECK SHALL accept only if key==stored key, amount<=src and dst+amount<=2^W-1; the sum is computed at W+1 bits.
REQ-024 On accept, CHECK SHALL go to WR_SRC; on reject, it SHALL set tx_reject and go to ANIMATE with no write.
REQ-025 WR_SRC SHALL write src-amount to address sender; WR_DST SHALL write dst+amount to address ~sender and set tx_ok.
REQ-026 amount=0 with a correct key SHALL be accepted and rewrite the unchanged values.
REQ-027 ANIMATE SHALL hold anim_active=1 for exactly ANIM_CYCLES cycles, then go to DONE.
REQ-028 DONE SHALL hold finished_transaction=1 until start_transaction=0, then return to IDLE with finished_transaction=0 in IDLE.
REQ-029 Latency from start_transaction rising to finished_transaction high SHALL be 7+ANIM_CYCLES cycles on accept and 5+ANIM_CYCLES on reject.
REQ-030 If start_transaction falls before WR_SRC, the FSM SHALL return to IDLE next cycle with no write and no status change.
REQ-031 Once WR_SRC is entered, both writes SHALL complete regardless of start_transaction.
REQ-032 mem_we SHALL be 0 in every state except WR_SRC and WR_DST.
REQ-033 tx_ok and tx_reject SHALL never be high simultaneously, and both SHALL hold their value until the next transaction starts.

Reset
REQ-034 reset SHALL force IDLE, clear the animation counter and captured registers, and drive mem_addr=0, mem_wdata=0, mem_we=0, finished_transaction=0, tx_ok=0, tx_reject=0 and anim_active=0.
REQ-035 reset asserted mid-transaction SHALL take priority over all transitions; a reset between WR_SRC and WR_DST leaves only the source write committed.

Structure
REQ-036 Memory address constants (P1_BAL, P2_BAL, P1_KEY, P2_KEY) and the state encoding SHALL live in a shared package used by the memory initialiser and the display path.
REQ-037 The animation counter SHALL be a sub-module, anim_timer, with inputs start and count and output done.

Verification
REQ-038 P1 bal=100, P2 bal=50, P1 key=0x3C; sender=0, amount=30, key=0x3C -> writes 70 to addr 0 and 80 to addr 1, tx_ok=1, finished_transaction after 7+ANIM_CYCLES cycles.
REQ-039 Same memory state, key=0x3D -> no mem_we pulse, tx_reject=1, finished_transaction after 5+ANIM_CYCLES cycles.
REQ-040 sender=1, P2 bal=20, amount=21 -> reject, balances unchanged; amount=20 -> P2 bal=0, P1 bal updated.
REQ-041 dst=250, amount=6 -> reject (overflow); amount=5 -> dst=255 accepted.
REQ-042 start_transaction dropped in RD_DST -> IDLE next cycle, no write; reset asserted in ANIMATE -> all outputs at reset values next cycle.
REQ-043 Hold start_transaction high for 10 cycles after DONE -> finished_transaction stays high, no second transaction starts until start_transaction goes low and then high again.

Source files
------------

// File: rtl/transaction_engine_pkg.sv
// rtl/transaction_engine_pkg.sv - shared memory map, state encoding and address helpers
package transaction_engine_pkg;

  // Memory map shared with the memory initialiser and the display path
  localparam logic [1:0] P1_BAL = 2'd0;
  localparam logic [1:0] P2_BAL = 2'd1;
  localparam logic [1:0] P1_KEY = 2'd2;
  localparam logic [1:0] P2_KEY = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_KEY,
    S_RD_SRC,
    S_RD_DST,
    S_CHECK,
    S_WR_SRC,
    S_WR_DST,
    S_ANIMATE,
    S_DONE
  } state_t;

  // Balance address of a player (0 = P1, 1 = P2)
  function automatic logic [1:0] bal_addr(input logic player);
    return player ? P2_BAL : P1_BAL;
  endfunction

  // Key address of a player (0 = P1, 1 = P2)
  function automatic logic [1:0] key_addr(input logic player);
    return player ? P2_KEY : P1_KEY;
  endfunction

endpackage

// File: rtl/transaction_engine_anim_timer.sv
// rtl/transaction_engine_anim_timer.sv - animation cycle counter
module anim_timer #(
  parameter int CYCLES = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_count,
  output logic o_done
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  // Counter is held at zero while start is high so every run begins fresh
  always_ff @(posedge i_clock) begin
    if (i_reset || i_start) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Done on the last counted cycle, so the caller sees exactly CYCLES count cycles
  assign o_done = i_count && (r_cnt == CW'(CYCLES - 1));

endmodule

// File: rtl/transaction_engine.sv
// rtl/transaction_engine.sv - key-checked balance transfer between two players
module transaction_engine
  import transaction_engine_pkg::*;
#(
  parameter int ANIM_CYCLES = 16,
  parameter int W           = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start_transaction,
  input  logic         i_sender,
  input  logic [W-1:0] i_amount,
  input  logic [W-1:0] i_key,
  output logic [1:0]   o_mem_addr,
  input  logic [W-1:0] i_mem_rdata,
  output logic [W-1:0] o_mem_wdata,
  output logic         o_mem_we,
  output logic         o_finished_transaction,
  output logic         o_tx_ok,
  output logic         o_tx_reject,
  output logic         o_anim_active
);

  state_t       r_state;
  logic         r_sender;
  logic [W-1:0] r_stored_key;
  logic [W-1:0] r_src;
  logic [W-1:0] r_dst_new;
  logic [1:0]   r_mem_addr;
  logic [W-1:0] r_mem_wdata;
  logic         r_mem_we;
  logic         r_finished;
  logic         r_tx_ok;
  logic         r_tx_reject;
  logic         r_anim_active;

  logic [W:0]   w_sum;
  logic         w_accept;
  logic         w_timer_start;
  logic         w_timer_count;
  logic         w_anim_done;

  // Destination balance arrives on i_mem_rdata during CHECK; the extra bit flags overflow
  assign w_sum    = {1'b0, i_mem_rdata} + {1'b0, i_amount};
  assign w_accept = (i_key == r_stored_key) && (i_amount <= r_src) && !w_sum[W];

  assign w_timer_start = (r_state != S_ANIMATE);
  assign w_timer_count = (r_state == S_ANIMATE);

  anim_timer #(
    .CYCLES (ANIM_CYCLES)
  ) u_anim_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (w_timer_start),
    .i_count (w_timer_count),
    .o_done  (w_anim_done)
  );

  // Transaction sequencer; memory address is registered one state ahead of the read capture
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_sender      <= 1'b0;
      r_stored_key  <= '0;
      r_src         <= '0;
      r_dst_new     <= '0;
      r_mem_addr    <= P1_BAL;
      r_mem_wdata   <= '0;
      r_mem_we      <= 1'b0;
      r_finished    <= 1'b0;
      r_tx_ok       <= 1'b0;
      r_tx_reject   <= 1'b0;
      r_anim_active <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_transaction) begin
            r_state     <= S_RD_KEY;
            r_sender    <= i_sender;
            r_tx_ok     <= 1'b0;
            r_tx_reject <= 1'b0;
            r_mem_addr  <= key_addr(i_sender);
          end
        end
        S_RD_KEY: begin
          if (!i_start_transaction) begin
            r_state    <= S_IDLE;
            r_mem_addr <= P1_BAL;
          end else begin
            r_state    <= S_RD_SRC;
            r_mem_addr <= bal_addr(r_sender);
          end
        end
        S_RD_SRC: begin
          if (!i_start_transaction) begin
            r_state    <= S_IDLE;
            r_mem_addr <= P1_BAL;
          end else begin
            r_state      <= S_RD_DST;
            r_stored_key <= i_mem_rdata;
            r_mem_addr   <= bal_addr(~r_sender);
          end
        end
        S_RD_DST: begin
          if (!i_start_transaction) begin
            r_state    <= S_IDLE;
            r_mem_addr <= P1_BAL;
          end else begin
            r_state <= S_CHECK;
            r_src   <= i_mem_rdata;
          end
        end
        S_CHECK: begin
          if (!i_start_transaction) begin
            r_state    <= S_IDLE;
            r_mem_addr <= P1_BAL;
          end else if (w_accept) begin
            r_state     <= S_WR_SRC;
            r_dst_new   <= w_sum[W-1:0];
            r_mem_addr  <= bal_addr(r_sender);
            r_mem_wdata <= r_src - i_amount;
            r_mem_we    <= 1'b1;
          end else begin
            r_state       <= S_ANIMATE;
            r_tx_reject   <= 1'b1;
            r_anim_active <= 1'b1;
          end
        end
        S_WR_SRC: begin
          // Committed: the second write goes out whatever start_transaction does
          r_state     <= S_WR_DST;
          r_mem_addr  <= bal_addr(~r_sender);
          r_mem_wdata <= r_dst_new;
          r_mem_we    <= 1'b1;
          r_tx_ok     <= 1'b1;
        end
        S_WR_DST: begin
          r_state       <= S_ANIMATE;
          r_anim_active <= 1'b1;
        end
        S_ANIMATE: begin
          if (w_anim_done) begin
            r_state       <= S_DONE;
            r_anim_active <= 1'b0;
            r_finished    <= 1'b1;
          end
        end
        S_DONE: begin
          if (!i_start_transaction) begin
            r_state    <= S_IDLE;
            r_finished <= 1'b0;
            r_mem_addr <= P1_BAL;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_addr             = r_mem_addr;
  assign o_mem_wdata            = r_mem_wdata;
  assign o_mem_we               = r_mem_we;
  assign o_finished_transaction = r_finished;
  assign o_tx_ok                = r_tx_ok;
  assign o_tx_reject            = r_tx_reject;
  assign o_anim_active          = r_anim_active;

endmodule

// File: tb/tb_transaction_engine.sv
// tb/tb_transaction_engine.sv - directed self-checking bench for transaction_engine
module tb_transaction_engine;

  localparam int N = 5;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sender = 1'b0;
  logic [W-1:0] amount = '0;
  logic [W-1:0] key = '0;
  logic [1:0]   mem_addr;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] mem_wdata;
  logic         mem_we;
  logic         fin;
  logic         tx_ok;
  logic         tx_rej;
  logic         anim;

  logic [W-1:0] mem [4];
  logic         ld_en = 1'b0;
  logic [1:0]   ld_addr = '0;
  logic [W-1:0] ld_data = '0;

  int we_cnt = 0;
  int both_cnt = 0;
  int n_pass = 0;
  int n_total = 0;

  transaction_engine #(
    .ANIM_CYCLES (N),
    .W           (W)
  ) dut (
    .i_clock                (clk),
    .i_reset                (rst),
    .i_start_transaction    (start),
    .i_sender               (sender),
    .i_amount               (amount),
    .i_key                  (key),
    .o_mem_addr             (mem_addr),
    .i_mem_rdata            (mem_rdata),
    .o_mem_wdata            (mem_wdata),
    .o_mem_we               (mem_we),
    .o_finished_transaction (fin),
    .o_tx_ok                (tx_ok),
    .o_tx_reject            (tx_rej),
    .o_anim_active          (anim)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model with a bench-side preload port
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  always @(negedge clk) begin
    if (tx_ok === 1'b1 && tx_rej === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic load(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load4(input logic [W-1:0] p1, input logic [W-1:0] p2,
                       input logic [W-1:0] k1, input logic [W-1:0] k2);
    load(2'd0, p1); load(2'd1, p2); load(2'd2, k1); load(2'd3, k2);
  endtask

  task automatic run_txn(input logic s, input logic [W-1:0] amt, input logic [W-1:0] k,
                         output int lat, output int anim_n);
    @(negedge clk);
    sender = s; amount = amt; key = k; start = 1'b1;
    lat = 0; anim_n = 0;
    while (fin !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (anim === 1'b1) anim_n++;
    end
  endtask

  task automatic end_txn(input string name);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    n_total++; if (fin !== 1'b0) $display("FAIL %s_fin_low: got %b expected 0", name, fin); else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (mem_addr !== 2'd0) $display("FAIL rst_addr: got %0d expected 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 8'd0) $display("FAIL rst_wdata: got %0d expected 0", mem_wdata); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b expected 0", mem_we); else n_pass++;
    n_total++; if (fin !== 1'b0) $display("FAIL rst_fin: got %b expected 0", fin); else n_pass++;
    n_total++; if ({tx_ok, tx_rej, anim} !== 3'b000) $display("FAIL rst_status: got %b expected 000", {tx_ok, tx_rej, anim}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_accept();
    int lat, an, w0;
    load4(8'd100, 8'd50, 8'h3C, 8'hA5);
    w0 = we_cnt;
    run_txn(1'b0, 8'd30, 8'h3C, lat, an);
    n_total++; if (lat !== 7 + N) $display("FAIL acc_latency: got %0d expected %0d", lat, 7 + N); else n_pass++;
    n_total++; if (we_cnt - w0 !== 2) $display("FAIL acc_writes: got %0d expected 2", we_cnt - w0); else n_pass++;
    n_total++; if (mem[0] !== 8'd70) $display("FAIL acc_p1: got %0d expected 70", mem[0]); else n_pass++;
    n_total++; if (mem[1] !== 8'd80) $display("FAIL acc_p2: got %0d expected 80", mem[1]); else n_pass++;
    n_total++; if ({tx_ok, tx_rej} !== 2'b10) $display("FAIL acc_status: got %b expected 10", {tx_ok, tx_rej}); else n_pass++;
    n_total++; if (an !== N) $display("FAIL acc_anim_cycles: got %0d expected %0d", an, N); else n_pass++;
    end_txn("acc");
    n_total++; if (tx_ok !== 1'b1) $display("FAIL acc_ok_held: got %b expected 1", tx_ok); else n_pass++;
  endtask

  task automatic test_bad_key();
    int lat, an, w0;
    load4(8'd100, 8'd50, 8'h3C, 8'hA5);
    w0 = we_cnt;
    run_txn(1'b0, 8'd30, 8'h3D, lat, an);
    n_total++; if (lat !== 5 + N) $display("FAIL key_latency: got %0d expected %0d", lat, 5 + N); else n_pass++;
    n_total++; if (we_cnt - w0 !== 0) $display("FAIL key_writes: got %0d expected 0", we_cnt - w0); else n_pass++;
    n_total++; if ({tx_ok, tx_rej} !== 2'b01) $display("FAIL key_status: got %b expected 01", {tx_ok, tx_rej}); else n_pass++;
    n_total++; if ({mem[0], mem[1]} !== {8'd100, 8'd50}) $display("FAIL key_bal: got %0d/%0d expected 100/50", mem[0], mem[1]); else n_pass++;
    n_total++; if (an !== N) $display("FAIL key_anim_cycles: got %0d expected %0d", an, N); else n_pass++;
    end_txn("key");
  endtask

  task automatic test_sender1();
    int lat, an;
    load4(8'd100, 8'd20, 8'h3C, 8'hA5);
    run_txn(1'b1, 8'd21, 8'hA5, lat, an);
    n_total++; if (lat !== 5 + N) $display("FAIL s1_rej_latency: got %0d expected %0d", lat, 5 + N); else n_pass++;
    n_total++; if ({mem[0], mem[1]} !== {8'd100, 8'd20}) $display("FAIL s1_rej_bal: got %0d/%0d expected 100/20", mem[0], mem[1]); else n_pass++;
    n_total++; if ({tx_ok, tx_rej} !== 2'b01) $display("FAIL s1_rej_status: got %b expected 01", {tx_ok, tx_rej}); else n_pass++;
    end_txn("s1_rej");
    run_txn(1'b1, 8'd20, 8'hA5, lat, an);
    n_total++; if (lat !== 7 + N) $display("FAIL s1_acc_latency: got %0d expected %0d", lat, 7 + N); else n_pass++;
    n_total++; if ({mem[0], mem[1]} !== {8'd120, 8'd0}) $display("FAIL s1_acc_bal: got %0d/%0d expected 120/0", mem[0], mem[1]); else n_pass++;
    n_total++; if ({tx_ok, tx_rej} !== 2'b10) $display("FAIL s1_acc_status: got %b expected 10", {tx_ok, tx_rej}); else n_pass++;
    end_txn("s1_acc");
  endtask

  task automatic test_overflow();
    int lat, an, w0;
    load4(8'd100, 8'd250, 8'h3C, 8'hA5);
    run_txn(1'b0, 8'd6, 8'h3C, lat, an);
    n_total++; if ({tx_ok, tx_rej} !== 2'b01) $display("FAIL ovf_rej_status: got %b expected 01", {tx_ok, tx_rej}); else n_pass++;
    n_total++; if ({mem[0], mem[1]} !== {8'd100, 8'd250}) $display("FAIL ovf_rej_bal: got %0d/%0d expected 100/250", mem[0], mem[1]); else n_pass++;
    end_txn("ovf_rej");
    run_txn(1'b0, 8'd5, 8'h3C, lat, an);
    n_total++; if ({tx_ok, tx_rej} !== 2'b10) $display("FAIL ovf_max_status: got %b expected 10", {tx_ok, tx_rej}); else n_pass++;
    n_total++; if ({mem[0], mem[1]} !== {8'd95, 8'd255}) $display("FAIL ovf_max_bal: got %0d/%0d expected 95/255", mem[0], mem[1]); else n_pass++;
    end_txn("ovf_max");
    w0 = we_cnt;
    run_txn(1'b0, 8'd0, 8'h3C, lat, an);
    n_total++; if (we_cnt - w0 !== 2) $display("FAIL zero_writes: got %0d expected 2", we_cnt - w0); else n_pass++;
    n_total++; if ({mem[0], mem[1]} !== {8'd95, 8'd255}) $display("FAIL zero_bal: got %0d/%0d expected 95/255", mem[0], mem[1]); else n_pass++;
    n_total++; if (lat !== 7 + N) $display("FAIL zero_latency: got %0d expected %0d", lat, 7 + N); else n_pass++;
    end_txn("zero");
  endtask

  task automatic test_abort();
    int lat, an, w0;
    load4(8'd100, 8'd50, 8'h3C, 8'hA5);
    w0 = we_cnt;
    @(negedge clk);
    sender = 1'b0; amount = 8'd30; key = 8'h3C; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    n_total++; if ({fin, tx_ok, tx_rej, anim} !== 4'b0000) $display("FAIL abort_outputs: got %b expected 0000", {fin, tx_ok, tx_rej, anim}); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_total++; if (we_cnt - w0 !== 0) $display("FAIL abort_writes: got %0d expected 0", we_cnt - w0); else n_pass++;
    n_total++; if ({mem[0], mem[1]} !== {8'd100, 8'd50}) $display("FAIL abort_bal: got %0d/%0d expected 100/50", mem[0], mem[1]); else n_pass++;
    run_txn(1'b0, 8'd30, 8'h3C, lat, an);
    n_total++; if (lat !== 7 + N) $display("FAIL abort_next_latency: got %0d expected %0d", lat, 7 + N); else n_pass++;
    end_txn("abort_next");
  endtask

  task automatic test_reset_animate();
    int cyc;
    load4(8'd100, 8'd50, 8'h3C, 8'hA5);
    @(negedge clk);
    sender = 1'b0; amount = 8'd30; key = 8'h3C; start = 1'b1;
    cyc = 0;
    while (anim !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_total++; if (anim !== 1'b1) $display("FAIL rsta_reach_animate: got %b expected 1", anim); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if ({fin, tx_ok, tx_rej, anim, mem_we} !== 5'b00000) $display("FAIL rsta_flags: got %b expected 00000", {fin, tx_ok, tx_rej, anim, mem_we}); else n_pass++;
    n_total++; if ({mem_addr, mem_wdata} !== 10'd0) $display("FAIL rsta_bus: got addr %0d wdata %0d expected 0/0", mem_addr, mem_wdata); else n_pass++;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
    n_total++; if ({fin, anim} !== 2'b00) $display("FAIL rsta_idle: got %b expected 00", {fin, anim}); else n_pass++;
  endtask

  task automatic test_hold_done();
    int lat, an, w0, held;
    load4(8'd100, 8'd50, 8'h3C, 8'hA5);
    w0 = we_cnt;
    run_txn(1'b0, 8'd30, 8'h3C, lat, an);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (fin === 1'b1) held++;
    end
    n_total++; if (held !== 10) $display("FAIL hold_fin_cycles: got %0d expected 10", held); else n_pass++;
    n_total++; if (we_cnt - w0 !== 2) $display("FAIL hold_writes: got %0d expected 2", we_cnt - w0); else n_pass++;
    end_txn("hold");
    run_txn(1'b0, 8'd30, 8'h3C, lat, an);
    n_total++; if (lat !== 7 + N) $display("FAIL hold_next_latency: got %0d expected %0d", lat, 7 + N); else n_pass++;
    n_total++; if ({mem[0], mem[1]} !== {8'd40, 8'd110}) $display("FAIL hold_next_bal: got %0d/%0d expected 40/110", mem[0], mem[1]); else n_pass++;
    end_txn("hold_next");
  endtask

  initial begin
    test_reset();
    test_accept();
    test_bad_key();
    test_sender1();
    test_overflow();
    test_abort();
    test_reset_animate();
    test_hold_done();
    n_total++; if (both_cnt !== 0) $display("FAIL ok_and_reject_together: got %0d cycles expected 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
